// File: rtl/pixel_pkg.sv
// Shared types and default constants for the pixel deserializer alignment controller.
// Widths are derived from the delays so that each counter is just wide enough.
package pixel_pkg;

    localparam int WORD_W = 7;
    localparam logic [WORD_W-1:0] CLK_PATTERN_DEF = 7'b1100011;

    localparam int RST_CYCLES_DEF    = 16;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int SLIP_WAIT_DEF     = 4;
    localparam int MATCH_COUNT_DEF   = 16;
    localparam int MAX_SLIPS_DEF     = 14;
    localparam int ERR_THRESH_DEF    = 4;
    localparam int RETRY_DELAY_DEF   = 256;

    localparam int SLIP_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DRST,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_SWAIT,
        ST_VERIFY,
        ST_ALIGNED,
        ST_FAIL
    } state_e;

    // Counters hold N-1 down to 0, so clog2(N) bits suffice.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic int max_delay(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int DLY_W = cnt_width(max_delay(RST_CYCLES_DEF, SETTLE_CYCLES_DEF,
                                               SLIP_WAIT_DEF, RETRY_DELAY_DEF));

endpackage

// File: rtl/pixel_delay_cnt.sv
// Loadable down-counter shared by the timed FSM states; done_o is high at zero.
module pixel_delay_cnt
    import pixel_pkg::*;
#(
    parameter int W = DLY_W
) (
    input  logic         clk_slow,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/pixel_align_ctrl.sv
// Training and supervision FSM for the 4-lane 7:1 pixel deserializer: reset, bitslip
// search on the clock lane, qualification of alignment, and link monitoring.
module pixel_align_ctrl
    import pixel_pkg::*;
#(
    parameter logic [WORD_W-1:0] CLK_PATTERN   = CLK_PATTERN_DEF,
    parameter int                RST_CYCLES    = RST_CYCLES_DEF,
    parameter int                SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int                SLIP_WAIT     = SLIP_WAIT_DEF,
    parameter int                MATCH_COUNT   = MATCH_COUNT_DEF,
    parameter int                MAX_SLIPS     = MAX_SLIPS_DEF,
    parameter int                ERR_THRESH    = ERR_THRESH_DEF,
    parameter int                RETRY_DELAY   = RETRY_DELAY_DEF
) (
    input  logic              clk_slow,
    input  logic              rst_n,
    input  logic              locked,
    input  logic [WORD_W-1:0] clk_word,
    input  logic              word_valid,
    input  logic              retrain,
    output logic              deser_rst,
    output logic              bitslip,
    output logic              aligned,
    output logic              align_err,
    output logic [SLIP_W-1:0] slip_count
);

    localparam int DLY_W_L = cnt_width(max_delay(RST_CYCLES, SETTLE_CYCLES, SLIP_WAIT, RETRY_DELAY));
    localparam int MATCH_W = cnt_width(MATCH_COUNT);
    localparam int ERR_W   = cnt_width(ERR_THRESH);

    state_e               state_q, state_d;
    logic [SLIP_W-1:0]    slip_q, slip_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 deser_rst_q, bitslip_q, aligned_q, align_err_q;
    logic                 is_match, is_mismatch, slips_left;
    logic                 entering, dly_done;
    logic [DLY_W_L-1:0]   dly_val;

    assign is_match    = word_valid && (clk_word == CLK_PATTERN);
    assign is_mismatch = word_valid && (clk_word != CLK_PATTERN);
    assign slips_left  = (slip_q < SLIP_W'(MAX_SLIPS));

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin : next_state
        state_d = state_q;
        if (!locked) begin
            state_d = ST_IDLE;
        end else if (retrain && (state_q != ST_IDLE)) begin
            state_d = ST_DRST;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_DRST;
                ST_DRST:   if (dly_done) state_d = ST_SETTLE;
                ST_SETTLE: if (dly_done) state_d = ST_CHECK;
                ST_CHECK: begin
                    if (is_match)         state_d = ST_VERIFY;
                    else if (is_mismatch) state_d = slips_left ? ST_SLIP : ST_FAIL;
                end
                ST_SLIP:   state_d = ST_SWAIT;
                ST_SWAIT:  if (dly_done) state_d = ST_CHECK;
                ST_VERIFY: begin
                    if (is_match && (match_q == MATCH_W'(MATCH_COUNT - 1))) state_d = ST_ALIGNED;
                    else if (is_mismatch) state_d = slips_left ? ST_SLIP : ST_FAIL;
                end
                ST_ALIGNED: begin
                    if (is_mismatch && (err_q == ERR_W'(ERR_THRESH - 1))) state_d = ST_DRST;
                end
                ST_FAIL:   if (dly_done) state_d = ST_DRST;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // A retrain while already in DRST counts as a fresh entry and restarts the hold.
    assign entering = (state_d != state_q) || ((state_d == ST_DRST) && locked && retrain);

    always_comb begin : delay_select
        dly_val = '0;
        case (state_d)
            ST_DRST:   dly_val = DLY_W_L'(RST_CYCLES - 1);
            ST_SETTLE: dly_val = DLY_W_L'(SETTLE_CYCLES - 1);
            ST_SWAIT:  dly_val = DLY_W_L'(SLIP_WAIT - 1);
            ST_FAIL:   dly_val = DLY_W_L'(RETRY_DELAY - 1);
            default:   dly_val = '0;
        endcase
    end

    pixel_delay_cnt #(
        .W (DLY_W_L)
    ) u_delay (
        .clk_slow   (clk_slow),
        .rst_n      (rst_n),
        .load_i     (entering),
        .load_val_i (dly_val),
        .done_o     (dly_done)
    );

    always_comb begin : counters_next
        match_d = '0;
        if (state_d == ST_VERIFY) begin
            match_d = (state_q == ST_VERIFY) ? (match_q + MATCH_W'(is_match)) : MATCH_W'(1);
        end

        err_d = '0;
        if ((state_d == ST_ALIGNED) && (state_q == ST_ALIGNED)) begin
            err_d = is_match ? '0 : (err_q + ERR_W'(is_mismatch));
        end

        slip_d = slip_q;
        if (entering && (state_d == ST_DRST)) begin
            slip_d = '0;
        end else if (entering && (state_d == ST_SLIP) && slips_left) begin
            slip_d = slip_q + SLIP_W'(1);
        end
    end

    // Outputs are decoded from the next state so each one is a clean flop output.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slip_q      <= '0;
            match_q     <= '0;
            err_q       <= '0;
            deser_rst_q <= 1'b1;
            bitslip_q   <= 1'b0;
            aligned_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slip_q      <= slip_d;
            match_q     <= match_d;
            err_q       <= err_d;
            deser_rst_q <= (state_d == ST_IDLE) || (state_d == ST_DRST);
            bitslip_q   <= (state_d == ST_SLIP);
            aligned_q   <= (state_d == ST_ALIGNED);
            align_err_q <= (state_d == ST_FAIL);
        end
    end

    assign deser_rst  = deser_rst_q;
    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_err  = align_err_q;
    assign slip_count = slip_q;

endmodule
